// File: rtl/udt_pkg.sv
// Shared UDT packet field positions, control type codes and the
// dispatch state encoding used by the control-packet router.
package udt_pkg;

  localparam int UDT_CTRL_FLAG_BIT = 63;
  localparam int UDT_TYPE_MSB      = 62;
  localparam int UDT_TYPE_LSB      = 48;

  localparam logic [14:0] UDT_HANDSHAKE = 15'd0;
  localparam logic [14:0] UDT_KEEPALIVE = 15'd1;
  localparam logic [14:0] UDT_ACK       = 15'd2;
  localparam logic [14:0] UDT_NAK       = 15'd3;
  localparam logic [14:0] UDT_SHUTDOWN  = 15'd5;
  localparam logic [14:0] UDT_ACK2      = 15'd6;
  localparam logic [14:0] UDT_MSGDROP   = 15'd7;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FWD_CLOSE = 2'd1,
    ST_FWD_CTRL  = 2'd2,
    ST_DROP      = 2'd3
  } disp_state_e;

  // Destination of a packet, judged from its first beat.
  function automatic disp_state_e classify(
    input logic [63:0] beat,
    input logic [14:0] close_type,
    input logic        drop_data
  );
    logic [14:0] ty;
    ty = beat[UDT_TYPE_MSB:UDT_TYPE_LSB];
    if (!beat[UDT_CTRL_FLAG_BIT])
      classify = drop_data ? ST_DROP : ST_FWD_CTRL;
    else if (ty == close_type)
      classify = ST_FWD_CLOSE;
    else if (ty <= UDT_MSGDROP)
      classify = ST_FWD_CTRL;
    else
      classify = ST_DROP;
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// One-deep AXI-stream register slice, latency 1; accepts a new
// beat whenever empty or being drained in the same cycle.
module axis_reg_slice (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        s_valid_i,
  input  logic [63:0] s_data_i,
  input  logic [7:0]  s_keep_i,
  input  logic        s_last_i,
  output logic        s_ready_o,
  output logic        m_valid_o,
  output logic [63:0] m_data_o,
  output logic [7:0]  m_keep_o,
  output logic        m_last_o,
  input  logic        m_ready_i
);

  logic        valid_q;
  logic [63:0] data_q;
  logic [7:0]  keep_q;
  logic        last_q;

  assign s_ready_o = !valid_q || m_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else if (s_ready_o) begin
      valid_q <= s_valid_i;
      if (s_valid_i) begin
        data_q <= s_data_i;
        keep_q <= s_keep_i;
        last_q <= s_last_i;
      end
    end
  end

  assign m_valid_o = valid_q;
  assign m_data_o  = data_q;
  assign m_keep_o  = keep_q;
  assign m_last_o  = last_q;

endmodule

// File: rtl/udt_ctrl_dispatch.sv
// Routes received UDT packets to the CLOSE or generic control path,
// discarding the rest and counting discards per category.
module udt_ctrl_dispatch
  import udt_pkg::*;
#(
  parameter logic [14:0] CLOSE_TYPE = 15'h0005,
  parameter int          CNT_W      = 16,
  parameter bit          DROP_DATA  = 1'b1
) (
  input  logic             core_clk,
  input  logic             core_rst_n,
  input  logic             s_tvalid_i,
  input  logic [63:0]      s_tdata_i,
  input  logic [7:0]       s_tkeep_i,
  input  logic             s_tlast_i,
  output logic             s_tready_o,
  output logic             close_tvalid_o,
  output logic [63:0]      close_tdata_o,
  output logic [7:0]       close_tkeep_o,
  output logic             close_tlast_o,
  input  logic             close_tready_i,
  output logic             ctrl_tvalid_o,
  output logic [63:0]      ctrl_tdata_o,
  output logic [7:0]       ctrl_tkeep_o,
  output logic             ctrl_tlast_o,
  input  logic             ctrl_tready_i,
  output logic [CNT_W-1:0] drop_data_cnt_o,
  output logic [CNT_W-1:0] drop_unk_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  disp_state_e state_q, state_d;
  disp_state_e first_dst, route;

  logic close_rdy, ctrl_rdy;
  logic close_in_vld, ctrl_in_vld;
  logic accept, first_acc, drop_first;
  logic unk_inc, data_inc;

  logic [CNT_W-1:0] data_cnt_q, data_cnt_d;
  logic [CNT_W-1:0] unk_cnt_q, unk_cnt_d;

  // In IDLE the destination comes straight from the beat on the bus.
  assign first_dst = classify(s_tdata_i, CLOSE_TYPE, DROP_DATA);
  assign route = (state_q == ST_IDLE) ? first_dst : state_q;

  always_comb begin
    s_tready_o = 1'b1;
    unique case (1'b1)
      route == ST_FWD_CLOSE: s_tready_o = close_rdy;
      route == ST_FWD_CTRL:  s_tready_o = ctrl_rdy;
      default:               s_tready_o = 1'b1;
    endcase
  end

  assign accept     = s_tvalid_i && s_tready_o;
  assign first_acc  = accept && (state_q == ST_IDLE);
  assign drop_first = first_acc && (first_dst == ST_DROP);
  assign unk_inc  = drop_first && s_tdata_i[UDT_CTRL_FLAG_BIT];
  assign data_inc = drop_first && !s_tdata_i[UDT_CTRL_FLAG_BIT];

  assign close_in_vld = s_tvalid_i && (route == ST_FWD_CLOSE);
  assign ctrl_in_vld  = s_tvalid_i && (route == ST_FWD_CTRL);

  always_comb begin
    state_d = state_q;
    if (accept)
      state_d = s_tlast_i ? ST_IDLE : route;
  end

  always_comb begin
    data_cnt_d = data_cnt_q;
    unk_cnt_d  = unk_cnt_q;
    if (data_inc && (data_cnt_q != '1))
      data_cnt_d = data_cnt_q + CNT_ONE;
    if (unk_inc && (unk_cnt_q != '1))
      unk_cnt_d = unk_cnt_q + CNT_ONE;
  end

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_q    <= ST_IDLE;
      data_cnt_q <= '0;
      unk_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      data_cnt_q <= data_cnt_d;
      unk_cnt_q  <= unk_cnt_d;
    end
  end

  assign drop_data_cnt_o = data_cnt_q;
  assign drop_unk_cnt_o  = unk_cnt_q;

  axis_reg_slice u_close (
    .clk_i     (core_clk),
    .rst_ni    (core_rst_n),
    .s_valid_i (close_in_vld),
    .s_data_i  (s_tdata_i),
    .s_keep_i  (s_tkeep_i),
    .s_last_i  (s_tlast_i),
    .s_ready_o (close_rdy),
    .m_valid_o (close_tvalid_o),
    .m_data_o  (close_tdata_o),
    .m_keep_o  (close_tkeep_o),
    .m_last_o  (close_tlast_o),
    .m_ready_i (close_tready_i)
  );

  axis_reg_slice u_ctrl (
    .clk_i     (core_clk),
    .rst_ni    (core_rst_n),
    .s_valid_i (ctrl_in_vld),
    .s_data_i  (s_tdata_i),
    .s_keep_i  (s_tkeep_i),
    .s_last_i  (s_tlast_i),
    .s_ready_o (ctrl_rdy),
    .m_valid_o (ctrl_tvalid_o),
    .m_data_o  (ctrl_tdata_o),
    .m_keep_o  (ctrl_tkeep_o),
    .m_last_o  (ctrl_tlast_o),
    .m_ready_i (ctrl_tready_i)
  );

endmodule
